// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind uart_rx: bytes strobed by rx_done are queued and offered show-ahead.
// Latency: one cycle from push to m_valid; when full, a byte is dropped unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_done,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign pop  = m_valid & m_ready;
  assign push = rx_done & ((count < CW'(DEPTH)) | pop);
  assign drop = rx_done & ~push;

  assign m_valid     = (count != '0);
  assign almost_full = (count >= CW'(AF_THRESH));
  assign m_data      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop coinciding with ovf_clr restarts the tally at one rather than zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued on push and compared on each pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic [7:0] drop_cnt;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .almost_full(almost_full), .overflow(overflow), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] sb[$];
  int         mcount = 0;
  logic [7:0] last_pop = '0;

  // One clock of stimulus; expected bytes enter the queue when accepted, leave when popped.
  task automatic step(input logic done, input logic [7:0] d, input logic rdy, input logic clr);
    logic mpop, mpush;
    logic [7:0] exp;
    rx_done = done; rx_data = d; m_ready = rdy; ovf_clr = clr;
    mpop  = (mcount != 0) && rdy;
    mpush = done && ((mcount < 16) || mpop);
    if (mpop) begin
      exp = sb.pop_front();
      vecs++;
      if (m_data !== exp) begin
        errs++;
        $display("FAIL pop_data: got %h expected %h", m_data, exp);
      end
      last_pop = m_data;
    end
    if (mpush) sb.push_back(d);
    mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    @(posedge clk); #1;
    rx_done = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    vecs++;
    if (count !== 5'(mcount)) begin
      errs++;
      $display("FAIL count_track: got %0d expected %0d", count, mcount);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    #1;
    vecs++; if (count !== 5'd0)    begin errs++; $display("FAIL rst_count: got %0d expected 0", count); end
    vecs++; if (m_valid !== 1'b0)  begin errs++; $display("FAIL rst_valid: got %b expected 0", m_valid); end
    vecs++; if (m_data !== 8'h00)  begin errs++; $display("FAIL rst_data: got %h expected 00", m_data); end
    vecs++; if (almost_full !== 1'b0) begin errs++; $display("FAIL rst_af: got %b expected 0", almost_full); end
    vecs++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errs++; $display("FAIL rst_ovf: got %b/%0d expected 0/0", overflow, drop_cnt);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    vecs++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errs++; $display("FAIL single_head: got v=%b d=%h expected v=1 d=a5", m_valid, m_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vecs++; if (m_valid !== 1'b0 || count !== 5'd0) begin
      errs++; $display("FAIL single_empty: got v=%b c=%0d expected v=0 c=0", m_valid, count);
    end
  endtask

  task automatic test_full_overflow;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 11 || i == 12) begin
        vecs++;
        if (almost_full !== (i == 12)) begin
          errs++; $display("FAIL af_edge: after push %0d got %b expected %b", i, almost_full, (i == 12));
        end
      end
    end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL full_count: got %0d expected 16", count); end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    vecs++; if (overflow !== 1'b1 || drop_cnt !== 8'd1 || count !== 5'd16) begin
      errs++; $display("FAIL drop: got ovf=%b cnt=%0d count=%0d expected 1/1/16", overflow, drop_cnt, count);
    end
    drain(16);
    vecs++; if (m_valid !== 1'b0 || last_pop !== 8'h10) begin
      errs++; $display("FAIL drain_end: got v=%b last=%h expected v=0 last=10", m_valid, last_pop);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    vecs++; if (overflow !== 1'b0 || count !== 5'd16) begin
      errs++; $display("FAIL full_pop: got ovf=%b count=%0d expected 0/16", overflow, count);
    end
    drain(16);
    vecs++; if (last_pop !== 8'h77) begin errs++; $display("FAIL full_pop_last: got %h expected 77", last_pop); end
  endtask

  task automatic test_back_to_back;
    int maxc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    drain(1);
    vecs++; if (maxc > 1) begin errs++; $display("FAIL b2b_count: got max %0d expected <=1", maxc); end
    vecs++; if (last_pop !== 8'h27 || m_valid !== 1'b0) begin
      errs++; $display("FAIL b2b_last: got %h v=%b expected 27 v=0", last_pop, m_valid);
    end
  endtask

  task automatic test_ovf_clr;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    vecs++; if (overflow !== 1'b1 || drop_cnt !== 8'd3) begin
      errs++; $display("FAIL drop3: got %b/%0d expected 1/3", overflow, drop_cnt);
    end
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    vecs++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      errs++; $display("FAIL clr_vs_drop: got %b/%0d expected 1/1", overflow, drop_cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    vecs++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errs++; $display("FAIL clr_alone: got %b/%0d expected 0/0", overflow, drop_cnt);
    end
    drain(16);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1;
    vecs++; if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errs++; $display("FAIL async_rst: got c=%0d v=%b d=%h expected 0/0/00", count, m_valid, m_data);
    end
    sb.delete();
    mcount = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    vecs++; if (m_data !== 8'h3C) begin errs++; $display("FAIL post_rst_head: got %h expected 3c", m_data); end
    drain(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_full_pop();
    test_back_to_back();
    test_ovf_clr();
    test_async_reset();
    vecs++; if (sb.size() != 0) begin errs++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
